// File: rtl/alu_result_stage.sv
// Result/status stage behind the 16-bit ALU adder: FWFT FIFO, sticky status, push counter.
// Optional flag-consistency check enabled by defining ALU_RESULT_FLAG_CHECK_EN.
module alu_result_stage #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] Z,
  input  logic             Sign,
  input  logic             Zero,
  input  logic             Carry,
  input  logic             Parity,
  input  logic             Overflow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_z,
  output logic [4:0]       out_flags,
  input  logic             clr_sticky,
  output logic             sticky_carry,
  output logic             sticky_ovf,
  output logic [CNTW-1:0]  result_count,
  output logic             flag_err
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem_z [DEPTH];
  logic [4:0]       r_mem_f [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_occ;
  logic             r_sc;
  logic             r_so;
  logic [CNTW-1:0]  r_cnt;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;

  assign w_full    = (r_occ == (AW+1)'(DEPTH));
  assign w_empty   = (r_occ == '0);
  assign in_ready  = ~w_full;
  assign out_valid = ~w_empty;
  assign w_push    = in_valid & ~w_full;
  assign w_pop     = ~w_empty & out_ready;

  // Empty FIFO presents zeros rather than stale storage.
  assign out_z     = w_empty ? '0 : r_mem_z[r_rptr];
  assign out_flags = w_empty ? '0 : r_mem_f[r_rptr];

  assign sticky_carry = r_sc;
  assign sticky_ovf   = r_so;
  assign result_count = r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_z[i] <= '0;
        r_mem_f[i] <= '0;
      end
    end else if (w_push) begin
      r_mem_z[r_wptr] <= Z;
      r_mem_f[r_wptr] <= {Overflow, Parity, Carry, Zero, Sign};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_occ  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + (AW+1)'(1);
        2'b01:   r_occ <= r_occ - (AW+1)'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sc  <= 1'b0;
      r_so  <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_sc <= (clr_sticky ? 1'b0 : r_sc) | (w_push & Carry);
      r_so <= (clr_sticky ? 1'b0 : r_so) | (w_push & Overflow);
      if (w_push) r_cnt <= r_cnt + CNTW'(1);
    end
  end

`ifdef ALU_RESULT_FLAG_CHECK_EN
  logic r_err;
  logic w_bad;

  assign w_bad = (Sign   != Z[WIDTH-1]) |
                 (Zero   != ~|Z) |
                 (Parity != ~^Z);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_err <= 1'b0;
    else if (w_push & w_bad) r_err <= 1'b1;
  end

  assign flag_err = r_err;
`else
  assign flag_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Randomized self-checking bench for alu_result_stage against a queue model.
// Expected flag_err follows ALU_RESULT_FLAG_CHECK_EN.
module tb_alu_result_stage;
  localparam int DEPTH = 4;

  logic        clk = 0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [15:0] Z;
  logic        Sign, Zero, Carry, Parity, Overflow;
  logic        out_valid, out_ready;
  logic [15:0] out_z;
  logic [4:0]  out_flags;
  logic        clr_sticky, sticky_carry, sticky_ovf;
  logic [15:0] result_count;
  logic        flag_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [20:0] m_q [$];
  logic        m_sc, m_so, m_err;
  logic [15:0] m_cnt;

  always #5 clk = ~clk;

  alu_result_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .Z(Z), .Sign(Sign), .Zero(Zero), .Carry(Carry),
    .Parity(Parity), .Overflow(Overflow),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_z(out_z), .out_flags(out_flags),
    .clr_sticky(clr_sticky),
    .sticky_carry(sticky_carry), .sticky_ovf(sticky_ovf),
    .result_count(result_count), .flag_err(flag_err)
  );

  task automatic check(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] good_flags(input logic [15:0] z,
                                            input logic c, input logic o);
    return {o, ~^z, c, ~|z, z[15]};
  endfunction

  task automatic check_all();
    logic [20:0] h;
    h = (m_q.size() != 0) ? m_q[0] : 21'd0;
    check("in_ready", 32'(in_ready), 32'(m_q.size() != DEPTH));
    check("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
    check("out_z", 32'(out_z), 32'(h[15:0]));
    check("out_flags", 32'(out_flags), 32'(h[20:16]));
    check("sticky_carry", 32'(sticky_carry), 32'(m_sc));
    check("sticky_ovf", 32'(sticky_ovf), 32'(m_so));
    check("result_count", 32'(result_count), 32'(m_cnt));
    check("flag_err", 32'(flag_err), 32'(m_err));
  endtask

  task automatic cyc(input logic iv, input logic [15:0] z,
                     input logic [4:0] f, input logic ordy,
                     input logic clr);
    logic push, pop, bad;
    in_valid = iv; Z = z; out_ready = ordy; clr_sticky = clr;
    {Overflow, Parity, Carry, Zero, Sign} = f;
    push = iv && (m_q.size() != DEPTH);
    pop  = (m_q.size() != 0) && ordy;
    bad  = (f[0] != z[15]) || (f[1] != (z == 16'd0)) ||
           (f[3] != ~^z);
    @(posedge clk);
    if (pop) void'(m_q.pop_front());
    if (push) m_q.push_back({f, z});
    m_sc = (clr ? 1'b0 : m_sc) | (push & f[2]);
    m_so = (clr ? 1'b0 : m_so) | (push & f[4]);
    if (push) m_cnt = m_cnt + 16'd1;
`ifdef ALU_RESULT_FLAG_CHECK_EN
    if (push && bad) m_err = 1'b1;
`endif
    @(negedge clk);
    check_all();
  endtask

  task automatic model_reset();
    m_q.delete();
    m_sc = 0; m_so = 0; m_err = 0; m_cnt = 0;
  endtask

  task automatic idle(input logic ordy);
    cyc(1'b0, 16'h0, 5'h0, ordy, 1'b0);
  endtask

  initial begin
    logic [15:0] z;
    logic        c, o;
    rst_n = 0; in_valid = 0; Z = 0; out_ready = 0; clr_sticky = 0;
    {Overflow, Parity, Carry, Zero, Sign} = 5'h0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    rst_n = 1;
    @(negedge clk);
    check_all();

    // basic FWFT latency
    cyc(1'b1, 16'h0000, 5'b01010, 1'b0, 1'b0);
    check("t1_flags", 32'(out_flags), 32'h0A);
    check("t1_count", 32'(result_count), 32'd1);
    idle(1'b1);

    // fill to full, refuse fifth, drain in order
    for (int i = 1; i <= 4; i++)
      cyc(1'b1, 16'(i), good_flags(16'(i), 1'b0, 1'b0), 1'b0, 1'b0);
    check("t2_full", 32'(in_ready), 32'd0);
    cyc(1'b1, 16'h0005, good_flags(16'h5, 1'b0, 1'b0), 1'b1, 1'b0);
    check("t2_refused_cnt", 32'(result_count), 32'd5);
    for (int i = 0; i < 4; i++) idle(1'b1);
    check("t2_empty", 32'(out_valid), 32'd0);

    // sticky set and clear-with-push
    cyc(1'b1, 16'h0000, good_flags(16'h0, 1'b1, 1'b0), 1'b1, 1'b0);
    cyc(1'b1, 16'h8000, good_flags(16'h8000, 1'b0, 1'b1), 1'b1, 1'b0);
    check("t3_sc", 32'(sticky_carry), 32'd1);
    check("t3_so", 32'(sticky_ovf), 32'd1);
    cyc(1'b1, 16'h1234, good_flags(16'h1234, 1'b1, 1'b0), 1'b1, 1'b1);
    check("t3_clr_sc", 32'(sticky_carry), 32'd1);
    check("t3_clr_so", 32'(sticky_ovf), 32'd0);
    idle(1'b1);
    idle(1'b1);

    // steady push+pop at occupancy 2
    for (int i = 0; i < 2; i++)
      cyc(1'b1, 16'(16'hA0 + i), good_flags(16'(16'hA0 + i), 1'b0, 1'b0),
          1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      z = 16'($urandom);
      cyc(1'b1, z, good_flags(z, 1'b0, 1'b0), 1'b1, 1'b0);
      check("t4_occ", 32'(m_q.size()), 32'd2);
    end
    idle(1'b1);
    idle(1'b1);

    // count wrap
    while (m_cnt != 16'hFFFF) begin
      z = 16'($urandom);
      cyc(1'b1, z, good_flags(z, 1'b0, 1'b0), 1'b1, 1'b0);
    end
    check("t4_ffff", 32'(result_count), 32'hFFFF);
    cyc(1'b1, 16'h7, good_flags(16'h7, 1'b0, 1'b0), 1'b1, 1'b0);
    check("t4_wrap", 32'(result_count), 32'd0);
    idle(1'b1);

    // inconsistent parity
    cyc(1'b1, 16'h0003, 5'b00000, 1'b1, 1'b0);
`ifdef ALU_RESULT_FLAG_CHECK_EN
    check("t6_err", 32'(flag_err), 32'd1);
`else
    check("t6_err", 32'(flag_err), 32'd0);
`endif
    cyc(1'b0, 16'h0, 5'h0, 1'b1, 1'b1);

    // random traffic, mostly consistent flags
    for (int i = 0; i < 400; i++) begin
      z = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
      c = 1'($urandom); o = 1'($urandom);
      cyc(1'($urandom_range(0, 3) != 0), z,
          ($urandom_range(0, 15) == 0) ? 5'($urandom) : good_flags(z, c, o),
          1'($urandom_range(0, 2) != 0), ($urandom_range(0, 9) == 0));
    end

    // async reset mid-stream at occupancy 3
    while (m_q.size() != 0) idle(1'b1);
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 16'hC0DE, good_flags(16'hC0DE, 1'b1, 1'b1), 1'b0, 1'b0);
    check("t5_pre_occ", 32'(m_q.size()), 32'd3);
    #2 rst_n = 0;
    #1;
    check("t5_valid", 32'(out_valid), 32'd0);
    check("t5_z", 32'(out_z), 32'd0);
    check("t5_sc", 32'(sticky_carry), 32'd0);
    check("t5_so", 32'(sticky_ovf), 32'd0);
    check("t5_cnt", 32'(result_count), 32'd0);
    check("t5_err", 32'(flag_err), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    check_all();
    for (int i = 0; i < 6; i++) begin
      z = 16'($urandom);
      cyc(1'($urandom), z, good_flags(z, 1'($urandom), 1'b0),
          1'($urandom), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
